binop_seq: RTL

BINOP_SEQ -- requirements
Module: binop_seq

---
 rtl/binop_seq.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/binop_seq.sv
// Sequential binary-operation unit: single-cycle ADD/SUB/SHL/SHR, iterative
// shift-add MUL and restoring DIV/MOD, with a valid/ready handshake on both sides.
module binop_seq #(
    parameter int W   = 8,
    parameter int SHW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] xout,
    output logic         ovf,
    output logic         dbz
);

    localparam int CW = $clog2(W);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);
    localparam logic [W:0]    W_VAL     = (W + 1)'(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_r;
    logic [2:0]    op_r;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  hi_r;
    logic [W-1:0]  lo_r;
    logic [CW-1:0] cnt_r;

    logic [W:0]    sum_s;
    logic [W-1:0]  fast_x_s;
    logic          fast_ovf_s;
    logic [W:0]    mul_sum_s;
    logic [W-1:0]  mul_hi_s;
    logic [W-1:0]  mul_lo_s;
    logic [W:0]    div_rem_s;
    logic [W:0]    div_trial_s;
    logic [W-1:0]  div_hi_s;
    logic [W-1:0]  div_lo_s;
    logic [W-1:0]  div_x_s;

    // Single-cycle results computed straight from the request operands
    always_comb begin
        sum_s      = {1'b0, a} + {1'b0, b};
        fast_x_s   = '0;
        fast_ovf_s = 1'b0;
        case (op)
            OP_ADD: begin
                fast_x_s   = sum_s[W-1:0];
                fast_ovf_s = sum_s[W];
            end
            OP_SUB: begin
                fast_x_s   = a - b;
                fast_ovf_s = (a < b);
            end
            OP_SHL: begin
                if ({1'b0, b} >= W_VAL) begin
                    fast_ovf_s = 1'b1;
                end else begin
                    fast_x_s = a << b[SHW-1:0];
                end
            end
            OP_SHR: begin
                if ({1'b0, b} >= W_VAL) begin
                    fast_ovf_s = 1'b1;
                end else begin
                    fast_x_s = a >> b[SHW-1:0];
                end
            end
            default: begin
                fast_x_s   = '0;
                fast_ovf_s = 1'b0;
            end
        endcase
    end

    // One iteration step: {hi,lo} is the product pair for MUL, {remainder,quotient} for DIV
    always_comb begin
        if (lo_r[0]) begin
            mul_sum_s = {1'b0, hi_r} + {1'b0, a_r};
        end else begin
            mul_sum_s = {1'b0, hi_r};
        end
        mul_hi_s    = mul_sum_s[W:1];
        mul_lo_s    = {mul_sum_s[0], lo_r[W-1:1]};
        div_rem_s   = {hi_r, lo_r[W-1]};
        div_trial_s = div_rem_s - {1'b0, b_r};
        if (!div_trial_s[W]) begin
            div_hi_s = div_trial_s[W-1:0];
            div_lo_s = {lo_r[W-2:0], 1'b1};
        end else begin
            div_hi_s = div_rem_s[W-1:0];
            div_lo_s = {lo_r[W-2:0], 1'b0};
        end
        if (b_r == '0) begin
            div_x_s = (op_r == OP_MOD) ? a_r : '1;
        end else begin
            div_x_s = (op_r == OP_MOD) ? div_hi_s : div_lo_s;
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            xout      <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
            op_r      <= 3'd0;
            a_r       <= '0;
            b_r       <= '0;
            hi_r      <= '0;
            lo_r      <= '0;
            cnt_r     <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        op_r     <= op;
                        a_r      <= a;
                        b_r      <= b;
                        cnt_r    <= '0;
                        hi_r     <= '0;
                        in_ready <= 1'b0;
                        case (op)
                            OP_MUL: begin
                                lo_r    <= b;
                                state_r <= S_MUL;
                            end
                            OP_DIV, OP_MOD: begin
                                lo_r    <= a;
                                state_r <= S_DIV;
                            end
                            default: begin
                                xout      <= fast_x_s;
                                ovf       <= fast_ovf_s;
                                dbz       <= 1'b0;
                                out_valid <= 1'b1;
                                state_r   <= S_DONE;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    hi_r  <= mul_hi_s;
                    lo_r  <= mul_lo_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST_ITER) begin
                        xout      <= mul_lo_s;
                        ovf       <= |mul_hi_s;
                        dbz       <= 1'b0;
                        out_valid <= 1'b1;
                        state_r   <= S_DONE;
                    end
                end
                S_DIV: begin
                    hi_r  <= div_hi_s;
                    lo_r  <= div_lo_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST_ITER) begin
                        xout      <= div_x_s;
                        ovf       <= 1'b0;
                        dbz       <= (b_r == '0);
                        out_valid <= 1'b1;
                        state_r   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
